wishbone_arbiter: RTL and testbench
===================================

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NM, default 3, number of upstream masters sharing one downstream port.
REQ-002 SHALL have parameters DW=32, AW=32, TW=3, SW=DW/8: data, address, tag and select widths.
REQ-003 SHALL have parameter TIMEOUT, default 255, stalled-strobe cycles before a bus error; minimum 2.
REQ-004 SHALL have port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports masters_cyc, masters_stb, masters_we  input  NM each  per-master cycle, strobe and write-enable.
REQ-007 SHALL have ports masters_tag, masters_sel, masters_adr, masters_mosi  input  NM*TW, NM*SW, NM*AW, NM*DW  per-master tag, select, address and write data; master m occupies slice m.
REQ-008 SHALL have ports masters_miso, masters_ack, masters_err  output  NM*DW, NM, NM  per-master read data, acknowledge and error.
REQ-009 SHALL have ports bus_cyc, bus_stb, bus_we, bus_tag, bus_sel, bus_adr, bus_mosi  output  1, 1, 1, TW, SW, AW, DW  shared downstream master port, feeding one crossbar master slot.
REQ-010 SHALL have ports bus_miso, bus_ack, bus_err  input  DW, 1, 1  downstream responses.

Function
REQ-011 SHALL implement two states: IDLE (no grant) and BUSY (one master granted).
REQ-012 In IDLE, when any masters_cyc is high, SHALL grant exactly one master, chosen round-robin starting at index (last+1) mod NM, and enter BUSY on the next edge; arbitration latency is one cycle.
REQ-013 In IDLE, all bus_* outputs SHALL be 0 and all masters_ack/err/miso SHALL be 0.
REQ-014 In BUSY, bus_* outputs SHALL combinationally equal the granted master's signals, and the granted master's miso/ack SHALL equal bus_miso/bus_ack.
REQ-015 In BUSY, non-granted masters SHALL see miso=0, ack=0, err=0.
REQ-016 The grant SHALL be held for as long as the granted master keeps cyc high, regardless of other requests.
REQ-017 When the granted master's cyc is low in BUSY, SHALL drive bus_cyc=0, record last=granted index and return to IDLE on that edge.
REQ-018 A stall counter SHALL increment each BUSY cycle with bus_stb=1 and bus_ack=0 and bus_err=0; otherwise it SHALL clear to 0.
REQ-019 When the stall counter equals TIMEOUT, the granted master's err SHALL be 1 for exactly that cycle (ORed with bus_err), bus_stb SHALL be forced 0 that cycle, and the counter SHALL clear.
REQ-020 Simultaneous bus_ack and timeout SHALL not occur; bus_ack in the timeout cycle SHALL take precedence (counter clears, no err).
REQ-021 Counter width SHALL be clog2(TIMEOUT+1); no wrap-around before TIMEOUT is reached.
REQ-022 A master dropping cyc mid-transfer SHALL abort: bus_cyc falls the same cycle; late bus_ack SHALL be discarded.

Reset
REQ-023 On sys_rst high at a clock edge: state=IDLE, last=NM-1 (master 0 wins first), stall counter=0.
REQ-024 Reset mid-BUSY SHALL drop the grant; all outputs SHALL be 0 in the cycle after the reset edge.
REQ-025 Outputs SHALL be 0 while sys_rst is asserted following its first edge.

Structure
REQ-026 State encoding constants (IDLE, BUSY) SHALL live in the shared SoC bus package alongside other Wishbone constants.
REQ-027 The round-robin selection SHALL be a sub-module rr_picker (inputs req[NM], last index; output one-hot grant and index), purely combinational.
REQ-028 Remaining logic (state register, last register, stall counter, muxing) SHALL be in wishbone_arbiter.

Verification
REQ-029 Reset, then masters_cyc=3'b111 -> grant master 0 one cycle later; bus_adr equals master 0 address.
REQ-030 Master 0 drops cyc with 1 and 2 still requesting -> IDLE for one cycle, then master 1 granted, next release grants master 2, then master 0.
REQ-031 Master 1 granted, master 0 asserts cyc mid-cycle -> master 1 retains grant until its cyc falls; master 0 sees ack=0 throughout.
REQ-032 TIMEOUT=4, granted stb held, no bus_ack -> granted master err=1 on the fifth BUSY stall cycle only, bus_stb=0 that cycle, counter then 0.
REQ-033 sys_rst pulsed while master 2 granted -> next cycle all outputs 0, state IDLE, master 0 wins next arbitration.
REQ-034 Read from master 1 with bus_miso=32'hDEADBEEF, bus_ack=1 -> masters_miso slice 1 = 32'hDEADBEEF, ack[1]=1, slices 0 and 2 = 0.

Source files
------------

// File: rtl/wishbone_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter_pkg
// Shared SoC bus package. Holds the arbiter state encoding next to the
// Wishbone-wide constants used by the bus blocks, plus a small helper that
// sizes master-index fields.
// No ports: imported by wishbone_arbiter and rr_picker.
// -----------------------------------------------------------------------------
package wishbone_arbiter_pkg;

   // Default Wishbone field widths used across the SoC bus fabric
   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 32;
   localparam int WB_TAG_W  = 3;

   // Arbiter FSM: IDLE means nobody owns the downstream port, BUSY means one
   // master has been granted and is being passed straight through
   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Width of a field that indexes one of n masters; never narrower than one
   // bit so a single-master build still elaborates cleanly
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wishbone_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Searches the request vector
// starting one past the previous winner and wrapping around, so the master
// that was served last has the lowest priority.
// Ports:
//   req   - per-master request (cyc) vector
//   last  - index of the previously served master
//   grant - one-hot winner (all zero when nobody requests)
//   idx   - binary index of the winner (0 when nobody requests)
// -----------------------------------------------------------------------------
module rr_picker
   import wishbone_arbiter_pkg::*;
#(
   parameter int NM = 3,
   parameter int IW = idx_width(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last,
   output logic [NM-1:0] grant,
   output logic [IW-1:0] idx
);

   logic found;

   // Two passes cover the rotated order: first the masters above the last
   // winner, then wrap to the bottom and scan up to and including it. The
   // first hit in that order wins and blocks everything after it.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int c = 0; c < NM; c++) begin
         if (!found && (c > int'(last)) && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
      for (int c = 0; c < NM; c++) begin
         if (!found && (c <= int'(last)) && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = IW'(c);
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
// Shares one downstream Wishbone master port between NM upstream masters.
// A master is granted one cycle after it raises cyc (round-robin among all
// requesters) and keeps the port until it drops cyc. While granted, its
// request fields pass straight to the bus and the bus responses pass straight
// back. A stall counter turns a strobe that is never acknowledged into an
// error towards the granted master after TIMEOUT stalled cycles.
// Ports:
//   sys_clk, sys_rst            - clock, synchronous active-high reset
//   masters_cyc/stb/we          - per-master control, bit m = master m
//   masters_tag/sel/adr/mosi    - per-master request fields, slice m = master m
//   masters_miso/ack/err        - per-master responses, zero unless granted
//   bus_cyc/stb/we/tag/sel/adr/mosi - shared downstream request
//   bus_miso/ack/err            - downstream responses
// -----------------------------------------------------------------------------
module wishbone_arbiter
   import wishbone_arbiter_pkg::*;
#(
   parameter int NM      = 3,
   parameter int DW      = WB_DATA_W,
   parameter int AW      = WB_ADDR_W,
   parameter int TW      = WB_TAG_W,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = 255
) (
   input  logic             sys_clk,
   input  logic             sys_rst,

   input  logic [NM-1:0]    masters_cyc,
   input  logic [NM-1:0]    masters_stb,
   input  logic [NM-1:0]    masters_we,
   input  logic [NM*TW-1:0] masters_tag,
   input  logic [NM*SW-1:0] masters_sel,
   input  logic [NM*AW-1:0] masters_adr,
   input  logic [NM*DW-1:0] masters_mosi,
   output logic [NM*DW-1:0] masters_miso,
   output logic [NM-1:0]    masters_ack,
   output logic [NM-1:0]    masters_err,

   output logic             bus_cyc,
   output logic             bus_stb,
   output logic             bus_we,
   output logic [TW-1:0]    bus_tag,
   output logic [SW-1:0]    bus_sel,
   output logic [AW-1:0]    bus_adr,
   output logic [DW-1:0]    bus_mosi,
   input  logic [DW-1:0]    bus_miso,
   input  logic             bus_ack,
   input  logic             bus_err
);

   localparam int            IW          = idx_width(NM);
   localparam int            CW          = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] last_q,  last_d;
   logic [CW-1:0] stall_q, stall_d;

   logic [NM-1:0] pick_onehot;
   logic [IW-1:0] pick_idx;

   logic          g_cyc, g_stb, g_we;
   logic [TW-1:0] g_tag;
   logic [SW-1:0] g_sel;
   logic [AW-1:0] g_adr;
   logic [DW-1:0] g_mosi;

   logic          active;
   logic          at_limit;
   logic          timeout;

   rr_picker #(
      .NM (NM),
      .IW (IW)
   ) u_picker (
      .req   (masters_cyc),
      .last  (last_q),
      .grant (pick_onehot),
      .idx   (pick_idx)
   );

   // Pull out the currently granted master's request fields. Every slice is
   // selected with a constant offset so the mux stays a plain AND-OR tree.
   always_comb begin
      g_cyc  = 1'b0;
      g_stb  = 1'b0;
      g_we   = 1'b0;
      g_tag  = '0;
      g_sel  = '0;
      g_adr  = '0;
      g_mosi = '0;
      for (int m = 0; m < NM; m++) begin
         if (grant_q == IW'(m)) begin
            g_cyc  = masters_cyc[m];
            g_stb  = masters_stb[m];
            g_we   = masters_we[m];
            g_tag  = masters_tag[m*TW +: TW];
            g_sel  = masters_sel[m*SW +: SW];
            g_adr  = masters_adr[m*AW +: AW];
            g_mosi = masters_mosi[m*DW +: DW];
         end
      end
   end

   // The pass-through is live only while the owner still holds cyc; the
   // moment it drops cyc the whole path goes quiet, which both aborts the
   // downstream cycle and throws away any late acknowledge. When the stall
   // counter sits at its limit the strobe is withheld so the slave sees the
   // request go away in the same cycle the master is told about the error.
   // An acknowledge arriving in that cycle wins over the timeout.
   always_comb begin
      active   = (state_q == ARB_BUSY) && g_cyc;
      at_limit = (stall_q == STALL_LIMIT);
      timeout  = active && at_limit && !bus_ack;

      bus_cyc      = active;
      bus_stb      = active && g_stb && !at_limit;
      bus_we       = active && g_we;
      bus_tag      = active ? g_tag  : '0;
      bus_sel      = active ? g_sel  : '0;
      bus_adr      = active ? g_adr  : '0;
      bus_mosi     = active ? g_mosi : '0;

      masters_miso = '0;
      masters_ack  = '0;
      masters_err  = '0;
      for (int m = 0; m < NM; m++) begin
         if (active && (grant_q == IW'(m))) begin
            masters_miso[m*DW +: DW] = bus_miso;
            masters_ack[m]           = bus_ack;
            masters_err[m]           = bus_err || timeout;
         end
      end
   end

   // Next-state logic. IDLE hands the port to the picker's choice whenever
   // anyone requests. BUSY holds the grant for as long as the owner keeps
   // cyc high and remembers it as the last winner on release. The stall
   // counter only survives cycles where the strobe is waiting on a slave
   // that has neither acknowledged nor errored; reaching the limit clears it.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      stall_d = '0;
      case (state_q)
         ARB_IDLE: begin
            if (|pick_onehot) begin
               state_d = ARB_BUSY;
               grant_d = pick_idx;
            end
         end
         ARB_BUSY: begin
            if (!g_cyc) begin
               state_d = ARB_IDLE;
               last_d  = grant_q;
            end else if (at_limit) begin
               stall_d = '0;
            end else if (g_stb && !bus_ack && !bus_err) begin
               stall_d = stall_q + 1'b1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State registers. Reset parks last on the top index so master 0 is the
   // first winner after reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         last_q  <= IW'(NM - 1);
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wishbone_arbiter
// Self-checking bench for wishbone_arbiter with three masters and a short
// TIMEOUT. Expected grant order comes from a round-robin reference model and
// is queued when requests are driven; expected read data is queued when the
// bus response is driven. Both are popped when the DUT shows the result.
// -----------------------------------------------------------------------------
module tb_wishbone_arbiter;

   localparam int NM      = 3;
   localparam int DW      = 32;
   localparam int AW      = 32;
   localparam int TW      = 3;
   localparam int SW      = 4;
   localparam int TIMEOUT = 4;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic [NM-1:0]    masters_cyc;
   logic [NM-1:0]    masters_stb;
   logic [NM-1:0]    masters_we;
   logic [NM*TW-1:0] masters_tag;
   logic [NM*SW-1:0] masters_sel;
   logic [NM*AW-1:0] masters_adr;
   logic [NM*DW-1:0] masters_mosi;
   logic [NM*DW-1:0] masters_miso;
   logic [NM-1:0]    masters_ack;
   logic [NM-1:0]    masters_err;
   logic             bus_cyc;
   logic             bus_stb;
   logic             bus_we;
   logic [TW-1:0]    bus_tag;
   logic [SW-1:0]    bus_sel;
   logic [AW-1:0]    bus_adr;
   logic [DW-1:0]    bus_mosi;
   logic [DW-1:0]    bus_miso;
   logic             bus_ack;
   logic             bus_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int model_last;
   int exp_grant_q[$];
   logic [DW-1:0] exp_data_q[$];

   wishbone_arbiter #(
      .NM      (NM),
      .DW      (DW),
      .AW      (AW),
      .TW      (TW),
      .SW      (SW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .masters_cyc  (masters_cyc),
      .masters_stb  (masters_stb),
      .masters_we   (masters_we),
      .masters_tag  (masters_tag),
      .masters_sel  (masters_sel),
      .masters_adr  (masters_adr),
      .masters_mosi (masters_mosi),
      .masters_miso (masters_miso),
      .masters_ack  (masters_ack),
      .masters_err  (masters_err),
      .bus_cyc      (bus_cyc),
      .bus_stb      (bus_stb),
      .bus_we       (bus_we),
      .bus_tag      (bus_tag),
      .bus_sel      (bus_sel),
      .bus_adr      (bus_adr),
      .bus_mosi     (bus_mosi),
      .bus_miso     (bus_miso),
      .bus_ack      (bus_ack),
      .bus_err      (bus_err)
   );

   // Free-running 100 MHz clock
   always #5 sys_clk = ~sys_clk;

   // Hard stop in case something deadlocks outside the bounded waits
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference round-robin: scan from last+1 upwards, wrapping
   function automatic int rr_pick(input logic [NM-1:0] req, input int last);
      logic [NM-1:0] r;
      for (int i = 1; i <= NM; i++) begin
         r = req >> ((last + i) % NM);
         if (r[0]) return (last + i) % NM;
      end
      return -1;
   endfunction

   function automatic logic [AW-1:0] adr_of(input int m);
      return 32'h1000_0000 + 32'(m) * 32'h100;
   endfunction

   task automatic next_edge();
      @(posedge sys_clk);
      #1;
   endtask

   // Wait (bounded) for the downstream cycle to open; report the tag seen and
   // how many falling edges it took
   task automatic wait_grant(output int tag, output int cycles, output bit ok);
      ok     = 1'b0;
      tag    = -1;
      cycles = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge sys_clk);
         if (bus_cyc) begin
            ok     = 1'b1;
            tag    = int'(bus_tag);
            cycles = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      sys_rst     = 1'b1;
      masters_cyc = '0;
      masters_stb = '0;
      masters_we  = '0;
      bus_miso    = '0;
      bus_ack     = 1'b0;
      bus_err     = 1'b0;
      for (int m = 0; m < NM; m++) begin
         masters_tag[m*TW +: TW]  = TW'(m);
         masters_sel[m*SW +: SW]  = 4'hF;
         masters_adr[m*AW +: AW]  = adr_of(m);
         masters_mosi[m*DW +: DW] = 32'hA0A0_0000 + 32'(m);
      end
      next_edge();
      next_edge();
      masters_cyc = 3'b111;
      masters_stb = 3'b111;
      next_edge();
      @(negedge sys_clk);
      tests_run++;
      if ({bus_cyc, bus_stb, bus_we} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_bus_ctrl: got %b required 000", {bus_cyc, bus_stb, bus_we});
      end
      tests_run++;
      if (bus_adr !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bus_adr: got %h required 0", bus_adr);
      end
      tests_run++;
      if ({masters_ack, masters_err} !== '0 || masters_miso !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_master_resp: ack %b err %b miso %h required all 0",
                  masters_ack, masters_err, masters_miso);
      end
      next_edge();
      sys_rst     = 1'b0;
      masters_cyc = '0;
      masters_stb = '0;
      model_last  = NM - 1;
   endtask

   task automatic test_round_robin();
      int tag, cycles, exp;
      bit ok;
      next_edge();
      masters_cyc = 3'b111;
      masters_stb = 3'b111;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp) begin
         tests_failed++;
         $display("[TB] FAIL rr_first_grant: got master %0d required %0d", tag, exp);
      end
      tests_run++;
      if (cycles !== 2) begin
         tests_failed++;
         $display("[TB] FAIL rr_latency: got %0d cycles required 2", cycles);
      end
      tests_run++;
      if (bus_adr !== adr_of(exp)) begin
         tests_failed++;
         $display("[TB] FAIL rr_bus_adr: got %h required %h", bus_adr, adr_of(exp));
      end
      model_last = exp;

      for (int step = 0; step < 3; step++) begin
         next_edge();
         masters_cyc = ~(NM'(1) << model_last);
         exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
         @(negedge sys_clk);
         tests_run++;
         if (bus_cyc !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_release_drop_cyc step %0d: got %b required 0", step, bus_cyc);
         end
         wait_grant(tag, cycles, ok);
         exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
         tests_run++;
         if (!ok || tag !== exp || cycles !== 2) begin
            tests_failed++;
            $display("[TB] FAIL rr_next_grant step %0d: got master %0d after %0d cycles required %0d after 2",
                     step, tag, cycles, exp);
         end
         model_last = exp;
      end
   endtask

   task automatic test_hold();
      int tag, cycles, exp;
      bit ok;
      next_edge();
      masters_cyc = '0;
      @(negedge sys_clk);
      next_edge();
      masters_cyc = 3'b010;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp) begin
         tests_failed++;
         $display("[TB] FAIL hold_initial_grant: got master %0d required %0d", tag, exp);
      end
      model_last = exp;
      next_edge();
      masters_cyc = 3'b011;
      bus_ack     = 1'b1;
      bus_miso    = 32'h1234_5678;
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         tests_run++;
         if (bus_cyc !== 1'b1 || int'(bus_tag) !== 1 || masters_ack !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL hold_keeps_grant cycle %0d: cyc %b tag %0d ack %b required 1, 1, 010",
                     c, bus_cyc, bus_tag, masters_ack);
         end
      end
      next_edge();
      masters_cyc = 3'b001;
      bus_ack     = 1'b0;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp) begin
         tests_failed++;
         $display("[TB] FAIL hold_handover: got master %0d required %0d", tag, exp);
      end
      model_last = exp;
      next_edge();
      masters_cyc = '0;
      @(negedge sys_clk);
   endtask

   task automatic test_read();
      int tag, cycles, exp;
      bit ok;
      logic [DW-1:0] exp_data;
      next_edge();
      masters_cyc = 3'b010;
      masters_stb = 3'b010;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp) begin
         tests_failed++;
         $display("[TB] FAIL read_grant: got master %0d required %0d", tag, exp);
      end
      model_last = exp;
      next_edge();
      bus_miso = 32'hDEAD_BEEF;
      bus_ack  = 1'b1;
      exp_data_q.push_back(32'hDEAD_BEEF);
      @(negedge sys_clk);
      tests_run++;
      if (masters_ack !== 3'b010) begin
         tests_failed++;
         $display("[TB] FAIL read_ack: got %b required 010", masters_ack);
      end
      exp_data = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 'x;
      tests_run++;
      if (masters_miso[DW +: DW] !== exp_data) begin
         tests_failed++;
         $display("[TB] FAIL read_data: got %h required %h", masters_miso[DW +: DW], exp_data);
      end
      tests_run++;
      if (masters_miso[0 +: DW] !== '0 || masters_miso[2*DW +: DW] !== '0) begin
         tests_failed++;
         $display("[TB] FAIL read_other_slices: got %h / %h required 0",
                  masters_miso[0 +: DW], masters_miso[2*DW +: DW]);
      end
      next_edge();
      masters_cyc = '0;
      @(negedge sys_clk);
      tests_run++;
      if (bus_cyc !== 1'b0 || masters_ack !== '0 || masters_miso !== '0) begin
         tests_failed++;
         $display("[TB] FAIL abort_late_ack: cyc %b ack %b miso %h required 0, 000, 0",
                  bus_cyc, masters_ack, masters_miso);
      end
      next_edge();
      bus_ack  = 1'b0;
      bus_miso = '0;
   endtask

   task automatic test_timeout();
      int tag, cycles, exp;
      bit ok;
      bit err_cycle;
      next_edge();
      masters_cyc = 3'b100;
      masters_stb = 3'b111;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp) begin
         tests_failed++;
         $display("[TB] FAIL timeout_grant: got master %0d required %0d", tag, exp);
      end
      model_last = exp;
      // Stall cycles counted from the first granted cycle: the error fires on
      // cycle TIMEOUT+1, the count restarts, and fires again TIMEOUT+1 later
      for (int c = 1; c <= 14; c++) begin
         if (c > 1) @(negedge sys_clk);
         err_cycle = (c == TIMEOUT + 1) || (c == 2 * (TIMEOUT + 1));
         tests_run++;
         if (masters_err !== (err_cycle ? 3'b100 : 3'b000) || bus_stb !== !err_cycle) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycle %0d: err %b stb %b required %b, %b", c,
                     masters_err, bus_stb, err_cycle ? 3'b100 : 3'b000, !err_cycle);
         end
      end
      next_edge();
      bus_ack = 1'b1;
      @(negedge sys_clk);
      tests_run++;
      if (masters_err !== 3'b000 || masters_ack !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL ack_beats_timeout: err %b ack %b required 000, 100", masters_err, masters_ack);
      end
      next_edge();
      bus_ack = 1'b0;
      @(negedge sys_clk);
      tests_run++;
      if (masters_err !== 3'b000 || bus_stb !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_after_ack: err %b stb %b required 000, 1", masters_err, bus_stb);
      end
   endtask

   task automatic test_reset_mid();
      int tag, cycles, exp;
      bit ok;
      next_edge();
      sys_rst     = 1'b1;
      masters_cyc = 3'b101;
      next_edge();
      sys_rst     = 1'b0;
      model_last  = NM - 1;
      exp_grant_q.push_back(rr_pick(masters_cyc, model_last));
      @(negedge sys_clk);
      tests_run++;
      if ({bus_cyc, bus_stb, bus_we} !== 3'b000 || bus_adr !== '0 || bus_mosi !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_bus: ctrl %b adr %h mosi %h required 0",
                  {bus_cyc, bus_stb, bus_we}, bus_adr, bus_mosi);
      end
      tests_run++;
      if (masters_ack !== '0 || masters_err !== '0 || masters_miso !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_masters: ack %b err %b miso %h required 0",
                  masters_ack, masters_err, masters_miso);
      end
      wait_grant(tag, cycles, ok);
      exp = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : -1;
      tests_run++;
      if (!ok || tag !== exp || cycles !== 1) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_next_grant: got master %0d after %0d cycles required %0d after 1",
                  tag, cycles, exp);
      end
      model_last = exp;
      tests_run++;
      if (exp_grant_q.size() !== 0 || exp_data_q.size() !== 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: %0d grants and %0d data left, required 0",
                  exp_grant_q.size(), exp_data_q.size());
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_round_robin();
      test_hold();
      test_read();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
